// File: rtl/pixel_write_sink.sv
// pixel_write_sink: receiving end of the drawer pixel stream.
// Clips off-screen writes, converts (x, y) to a linear framebuffer address,
// buffers {addr, colour} in a small FIFO and drains one pixel per clock
// into the framebuffer write port whenever that port is free.
// Optional: define PIXEL_SINK_CLIP_COUNT_EN to build the clipped-pixel counter.
module pixel_write_sink #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int ADDR_W     = 15,
    parameter int COLOUR_W   = 9
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [7:0]          in_x,
    input  logic [6:0]          in_y,
    input  logic [COLOUR_W-1:0] in_colour,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                fb_busy,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [COLOUR_W-1:0] fb_data,
    output logic                fb_we,
    input  logic                count_clear,
    output logic [11:0]         pix_count,
    output logic [7:0]          clip_count,
    output logic                idle
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              EW       = ADDR_W + COLOUR_W;
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0]     W_LIM    = SCREEN_W;
    localparam logic [31:0]     H_LIM    = SCREEN_H;
    localparam logic [ADDR_W-1:0] W_MUL  = ADDR_W'(SCREEN_W);

    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         cnt_q, cnt_d;
    logic                full, empty, clipped, push, pop;
    logic [ADDR_W-1:0]   in_addr;
    logic [ADDR_W-1:0]   fb_addr_q;
    logic [COLOUR_W-1:0] fb_data_q;
    logic                fb_we_q;
    logic [11:0]         pix_count_q;

    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    // in_ready depends only on registered occupancy, so a pop in the same
    // cycle never re-opens a full FIFO.
    assign in_ready = !full;
    assign clipped  = ({24'd0, in_x} >= W_LIM) || ({25'd0, in_y} >= H_LIM);
    // Constant multiply; for a 160-wide screen this reduces to (y<<7)+(y<<5)+x.
    assign in_addr  = ADDR_W'(in_y) * W_MUL + ADDR_W'(in_x);
    // Clipped pixels still complete the handshake but are never stored.
    assign push     = in_valid && in_ready && !clipped;
    // fb_busy only gates the pop decision; a strobe already issued stands.
    assign pop      = !empty && !fb_busy;

    assign fb_addr   = fb_addr_q;
    assign fb_data   = fb_data_q;
    assign fb_we     = fb_we_q;
    assign pix_count = pix_count_q;
    assign idle      = empty && !fb_we_q;

    // Occupancy next-state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_addr, in_colour};
    end

    // FIFO pointers and occupancy; reset discards anything buffered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Framebuffer write port: load head entry on pop, strobe for one cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            fb_we_q <= pop;
            if (pop) {fb_addr_q, fb_data_q} <= mem_q[rd_ptr_q];
        end
    end

    // Written-pixel counter, saturating; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!resetn || count_clear)
            pix_count_q <= '0;
        else if (fb_we_q && pix_count_q != 12'hFFF)
            pix_count_q <= pix_count_q + 12'd1;
    end

`ifdef PIXEL_SINK_CLIP_COUNT_EN
    logic [7:0] clip_count_q;
    assign clip_count = clip_count_q;

    // Clipped-pixel counter, saturating; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!resetn || count_clear)
            clip_count_q <= '0;
        else if (in_valid && in_ready && clipped && clip_count_q != 8'hFF)
            clip_count_q <= clip_count_q + 8'd1;
    end
`else
    assign clip_count = '0;
`endif

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed bench for pixel_write_sink with an expected-write scoreboard.
module tb_pixel_write_sink;

    localparam int W = 160;
    localparam int H = 120;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  in_x = '0;
    logic [6:0]  in_y = '0;
    logic [8:0]  in_colour = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        fb_busy = 1'b0;
    logic [14:0] fb_addr;
    logic [8:0]  fb_data;
    logic        fb_we;
    logic        count_clear = 1'b0;
    logic [11:0] pix_count;
    logic [7:0]  clip_count;
    logic        idle;

    pixel_write_sink dut (
        .clk(clk), .resetn(resetn),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
        .in_valid(in_valid), .in_ready(in_ready),
        .fb_busy(fb_busy), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
        .count_clear(count_clear), .pix_count(pix_count),
        .clip_count(clip_count), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] a;
        logic [8:0]  d;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_in, e_out;
    int          checks = 0, failures = 0;
    int          we_total = 0, acc_total = 0, we_run = 0, max_run = 0;
    logic [14:0] last_addr = '0;

`ifdef PIXEL_SINK_CLIP_COUNT_EN
    localparam int EXP_CLIP = 2;
`else
    localparam int EXP_CLIP = 0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Input side: every accepted in-range pixel becomes an expected write.
    always @(negedge clk) begin
        if (!resetn) exp_q.delete();
        else if (in_valid && in_ready) begin
            acc_total++;
            if (int'(in_x) < W && int'(in_y) < H) begin
                e_in.a = 15'(int'(in_y) * W + int'(in_x));
                e_in.d = in_colour;
                exp_q.push_back(e_in);
            end
        end
    end

    // Output side: each strobe must match the oldest outstanding pixel.
    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            we_total++;
            we_run++;
            if (we_run > max_run) max_run = we_run;
            last_addr = fb_addr;
            if (exp_q.size() == 0) check("unexpected_we", 1, 0);
            else begin
                e_out = exp_q.pop_front();
                check("fb_addr", fb_addr, e_out.a);
                check("fb_data", fb_data, e_out.d);
            end
        end else we_run = 0;
    end

    // Called at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send(input int x, input int y, input int c);
        int n;
        in_x = 8'(x); in_y = 7'(y); in_colour = 9'(c); in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin n++; @(negedge clk); end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle_wait();
        int n;
        n = 0;
        @(negedge clk);
        while (!(idle === 1'b1 && exp_q.size() == 0) && n < 200) begin n++; @(negedge clk); end
        check("drain_idle", idle, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int w0, a0, n;

        // Reset state
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        check("rst_pix_count", pix_count, 0);
        check("rst_clip_count", clip_count, 0);
        check("rst_idle", idle, 1);

        // Single pixel and latency
        send(39, 39, 'h1FF);
        in_valid = 1'b0;
        @(negedge clk) check("lat_after_k", fb_we, 0);
        @(negedge clk) check("lat_after_k1", fb_we, 1);
        check("single_addr", fb_addr, 6279);
        check("single_data", fb_data, 'h1FF);
        @(negedge clk) check("single_pulse", fb_we, 0);
        @(posedge clk); #1;
        idle_wait();
        check("single_pix", pix_count, 1);

        // Bottom-right corner
        send(159, 119, 'h0AA);
        in_valid = 1'b0;
        idle_wait();
        check("corner_addr", last_addr, 19199);
        check("corner_pix", pix_count, 2);

        // Clipped pixels
        w0 = we_total; a0 = acc_total;
        send(160, 0, 'h011);
        send(0, 120, 'h022);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("clip_accepted", acc_total - a0, 2);
        check("clip_no_we", we_total - w0, 0);
        check("clip_pix", pix_count, 2);
        check("clip_count", clip_count, EXP_CLIP);

        // Back-pressure
        fb_busy = 1'b1;
        w0 = we_total; a0 = acc_total;
        for (int i = 0; i < 4; i++) send(10 + i, 5, i + 1);
        in_x = 8'd14; in_y = 7'd5; in_colour = 9'd5; in_valid = 1'b1;
        repeat (3) @(negedge clk) check("bp_ready_low", in_ready, 0);
        @(posedge clk); #1;
        check("bp_accepted", acc_total - a0, 4);
        check("bp_no_we", we_total - w0, 0);
        max_run = 0;
        fb_busy = 1'b0;
        send(14, 5, 5);
        send(15, 5, 6);
        in_valid = 1'b0;
        idle_wait();
        check("bp_writes", we_total - w0, 6);
        check("bp_consecutive", max_run >= 4, 1);
        check("bp_pix", pix_count, 8);

        // Reset mid-burst
        fb_busy = 1'b1;
        send(1, 1, 1);
        send(2, 2, 2);
        in_valid = 1'b0;
        w0 = we_total;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        fb_busy = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_no_we", we_total - w0, 0);
        check("mid_rst_pix", pix_count, 0);
        check("mid_rst_idle", idle, 1);
        check("mid_rst_ready", in_ready, 1);

        // Full 80x40 raster burst
        w0 = we_total;
        for (int y = 39; y <= 78; y++)
            for (int x = 39; x <= 118; x++)
                send(x, y, (x ^ y) & 'h1FF);
        in_valid = 1'b0;
        idle_wait();
        check("burst_writes", we_total - w0, 3200);
        check("burst_pix", pix_count, 3200);
        check("burst_last_addr", last_addr, 12598);

        // Clear colliding with an increment
        send(3, 3, 3);
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (fb_we !== 1'b1 && n < 20) begin n++; @(negedge clk); end
        check("clr_we_seen", fb_we, 1);
        count_clear = 1'b1;
        @(posedge clk); #1;
        count_clear = 1'b0;
        check("clr_collision_pix", pix_count, 0);
        idle_wait();
        check("clr_after_pix", pix_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
